// File: rtl/uart_text_cmd_decoder.sv
// UART text command decoder: assembles col/row/char[/attr] byte packets from the
// UART receiver, range-checks the coordinates and issues one back-pressured write
// per valid packet into the character/attribute buffer. Dropped packets, overrun
// bytes and mid-packet timeouts raise err_o and bump a saturating counter.
module uart_text_cmd_decoder #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned ADDR_W       = 12,
  parameter bit          ATTR_EN      = 1'b0,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h0F,
  parameter int unsigned TIMEOUT_CYC  = 20000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ferr_i,
  input  logic              wr_ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_char_o,
  output logic [7:0]        wr_attr_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StCol, StRow, StChar, StAttr, StChk, StWrite} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        col_q, col_d, row_q, row_d, char_q, char_d, attr_q, attr_d;
  logic              wr_en_d, err_d, in_range;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_char_d, wr_attr_d;

  assign in_range = (32'(col_q) < COLS) && (32'(row_q) < ROWS);

  // Next-state, packet assembly and error-event merging (one err per cycle max).
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    col_d     = col_q;
    row_d     = row_q;
    char_d    = char_q;
    attr_d    = attr_q;
    wr_en_d   = wr_en_o;
    wr_addr_d = wr_addr_o;
    wr_char_d = wr_char_o;
    wr_attr_d = wr_attr_o;
    err_d     = 1'b0;
    unique case (state_q)
      StCol: begin
        timer_d = '0;
        if (rx_valid_i) begin
          if (rx_ferr_i) begin
            err_d = 1'b1;
          end else begin
            col_d   = rx_data_i;
            state_d = StRow;
          end
        end
      end
      StRow, StChar, StAttr: begin
        if (rx_valid_i) begin
          // A byte arriving on the expiry cycle still wins over the timeout.
          timer_d = '0;
          if (rx_ferr_i) begin
            err_d   = 1'b1;
            state_d = StCol;
          end else if (state_q == StRow) begin
            row_d   = rx_data_i;
            state_d = StChar;
          end else if (state_q == StChar) begin
            char_d  = rx_data_i;
            state_d = ATTR_EN ? StAttr : StChk;
          end else begin
            attr_d  = rx_data_i;
            state_d = StChk;
          end
        end else if (timer_q == TMAX) begin
          timer_d = '0;
          err_d   = 1'b1;
          state_d = StCol;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StChk: begin
        if (rx_valid_i) err_d = 1'b1;
        if (in_range) begin
          wr_addr_d = ADDR_W'(32'(row_q) * COLS + 32'(col_q));
          wr_char_d = char_q;
          wr_attr_d = ATTR_EN ? attr_q : DEFAULT_ATTR;
          wr_en_d   = 1'b1;
          state_d   = StWrite;
        end else begin
          err_d   = 1'b1;
          state_d = StCol;
        end
      end
      StWrite: begin
        if (rx_valid_i) err_d = 1'b1;
        if (wr_ready_i) begin
          wr_en_d = 1'b0;
          state_d = StCol;
        end
      end
      default: state_d = StCol;
    endcase
  end

  // State, packet bytes and registered outputs; reset aborts everything at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StCol;
      timer_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      char_q     <= '0;
      attr_q     <= '0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_char_o  <= '0;
      wr_attr_o  <= '0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      col_q     <= col_d;
      row_q     <= row_d;
      char_q    <= char_d;
      attr_q    <= attr_d;
      wr_en_o   <= wr_en_d;
      wr_addr_o <= wr_addr_d;
      wr_char_o <= wr_char_d;
      wr_attr_o <= wr_attr_d;
      busy_o    <= (state_d != StCol);
      err_o     <= err_d;
      if (err_d && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_text_cmd_decoder.sv
// Bench for uart_text_cmd_decoder: dut_a runs 3-byte packets, dut_b 4-byte packets
// with attribute. Both share the byte/ready stimulus; the idle one is held in reset.
module tb_uart_text_cmd_decoder;

  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic rx_valid = 1'b0, rx_ferr = 1'b0, rdy = 1'b1;
  logic [7:0] rx_data = '0;

  logic        wr_en_a, busy_a, err_a, wr_en_b, busy_b, err_b;
  logic [11:0] wr_addr_a, wr_addr_b;
  logic [7:0]  wr_char_a, wr_attr_a, drop_a, wr_char_b, wr_attr_b, drop_b;

  int total = 0, bad = 0;
  int nerr_a = 0, nerr_b = 0;
  logic [27:0] got_a[$], got_b[$], exp_q[$];
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  uart_text_cmd_decoder #(.ATTR_EN(1'b0), .TIMEOUT_CYC(TO)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_ferr_i(rx_ferr), .wr_ready_i(rdy), .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a),
    .wr_char_o(wr_char_a), .wr_attr_o(wr_attr_a), .busy_o(busy_a), .err_o(err_a),
    .drop_cnt_o(drop_a)
  );

  uart_text_cmd_decoder #(.ATTR_EN(1'b1), .TIMEOUT_CYC(TO)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_ferr_i(rx_ferr), .wr_ready_i(rdy), .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b),
    .wr_char_o(wr_char_b), .wr_attr_o(wr_attr_b), .busy_o(busy_b), .err_o(err_b),
    .drop_cnt_o(drop_b)
  );

  // Record accepted writes and error pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst_a && wr_en_a && rdy) got_a.push_back({wr_addr_a, wr_char_a, wr_attr_a});
    if (!rst_b && wr_en_b && rdy) got_b.push_back({wr_addr_b, wr_char_b, wr_attr_b});
    if (!rst_a && err_a) nerr_a++;
    if (!rst_b && err_b) nerr_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b, input logic fe);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_ferr  = fe;
    tick();
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  task automatic send3(input logic [7:0] c, input logic [7:0] r, input logic [7:0] ch);
    send(c, 1'b0);
    send(r, 1'b0);
    send(ch, 1'b0);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en_a), 0);
    chk({tag, "_addr"}, 32'(wr_addr_a), 0);
    chk({tag, "_char"}, 32'(wr_char_a), 0);
    chk({tag, "_attr"}, 32'(wr_attr_a), 0);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_err"}, 32'(err_a), 0);
    chk({tag, "_drop"}, 32'(drop_a), 0);
  endtask

  initial begin
    int n0, w, exp_drop, c, r, ch, fpos;
    bit ovr, badp;
    logic [7:0] pk[3];

    // Reset state of both instances.
    tick(); tick();
    chk_zero_a("rst");
    chk("rst_b_wr_en", 32'(wr_en_b), 0);
    chk("rst_b_attr", 32'(wr_attr_b), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    rst_a = 1'b0;
    tick();

    // 1: baseline write, exact latency and single-cycle pulse.
    n0 = nerr_a;
    send3(8'h00, 8'h00, 8'h41);
    chk("t1_chk_cycle_wr_en", 32'(wr_en_a), 0);
    tick();
    chk("t1_wr_en", 32'(wr_en_a), 1);
    chk("t1_addr", 32'(wr_addr_a), 0);
    chk("t1_char", 32'(wr_char_a), 32'h41);
    chk("t1_attr", 32'(wr_attr_a), 32'h0F);
    tick();
    chk("t1_wr_en_drop", 32'(wr_en_a), 0);
    chk("t1_busy", 32'(busy_a), 0);
    tick();
    chk("t1_nwrites", 32'(got_a.size()), 1);
    chk("t1_no_err", 32'(nerr_a - n0), 0);

    // 2: last cell.
    send3(8'd79, 8'd29, 8'h5A);
    tick();
    chk("t2_wr_en", 32'(wr_en_a), 1);
    chk("t2_addr", 32'(wr_addr_a), 2399);
    chk("t2_char", 32'(wr_char_a), 32'h5A);
    tick();

    // 3: column out of range, then a normal packet.
    got_a.delete();
    send3(8'd80, 8'd0, 8'h41);
    tick();
    chk("t3_err", 32'(err_a), 1);
    chk("t3_drop", 32'(drop_a), 1);
    chk("t3_busy", 32'(busy_a), 0);
    chk("t3_wr_en", 32'(wr_en_a), 0);
    tick();
    chk("t3_err_pulse", 32'(err_a), 0);
    send3(8'd3, 8'd2, 8'h44);
    tick();
    chk("t3_next_addr", 32'(wr_addr_a), 163);
    tick(); tick();
    chk("t3_nwrites", 32'(got_a.size()), 1);

    // 4a: idle of TO-1 cycles is tolerated.
    send(8'd5, 1'b0);
    send(8'd3, 1'b0);
    repeat (TO - 1) tick();
    chk("t4_noto_busy", 32'(busy_a), 1);
    chk("t4_noto_err", 32'(err_a), 0);
    send(8'h44, 1'b0);
    tick();
    chk("t4_noto_wr_en", 32'(wr_en_a), 1);
    chk("t4_noto_addr", 32'(wr_addr_a), 245);
    tick();

    // 4b: idle of TO cycles aborts; following packet is clean.
    send(8'd5, 1'b0);
    send(8'd3, 1'b0);
    repeat (TO - 1) tick();
    chk("t4_pre_err", 32'(err_a), 0);
    tick();
    chk("t4_to_err", 32'(err_a), 1);
    chk("t4_to_drop", 32'(drop_a), 2);
    chk("t4_to_busy", 32'(busy_a), 0);
    send3(8'd1, 8'd2, 8'h42);
    tick();
    chk("t4_addr", 32'(wr_addr_a), 161);
    chk("t4_char", 32'(wr_char_a), 32'h42);
    tick();

    // 6a: framing error on the row byte.
    send(8'd7, 1'b0);
    send(8'd1, 1'b1);
    chk("t6_ferr_err", 32'(err_a), 1);
    chk("t6_ferr_busy", 32'(busy_a), 0);
    chk("t6_ferr_drop", 32'(drop_a), 3);
    tick();

    // 6b: reset after the row byte, then reset mid-write under back-pressure.
    send(8'd4, 1'b0);
    send(8'd5, 1'b0);
    rst_a = 1'b1;
    #1;
    chk_zero_a("t6_rst_pkt");
    tick();
    rst_a = 1'b0;
    rdy = 1'b0;
    got_a.delete();
    send3(8'd1, 8'd1, 8'h41);
    tick();
    chk("t6_stall_wr_en", 32'(wr_en_a), 1);
    rst_a = 1'b1;
    #1;
    chk("t6_rst_wr_en", 32'(wr_en_a), 0);
    tick();
    rst_a = 1'b0;
    rdy = 1'b1;
    tick(); tick();
    chk("t6_no_write", 32'(got_a.size()), 0);
    send3(8'h00, 8'h00, 8'h41);
    tick();
    chk("t6_after_wr_en", 32'(wr_en_a), 1);
    chk("t6_after_addr", 32'(wr_addr_a), 0);
    chk("t6_after_char", 32'(wr_char_a), 32'h41);
    tick();

    // Random packets against a packet-level model.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    got_a.delete();
    exp_q.delete();
    exp_drop = 0;
    n0 = nerr_a;
    rand_rdy = 1'b1;
    for (int p = 0; p < 80; p++) begin
      c = int'($urandom_range(0, 95));
      r = int'($urandom_range(0, 35));
      ch = int'($urandom_range(0, 255));
      fpos = int'($urandom_range(0, 7));
      ovr = ($urandom_range(0, 3) == 0);
      pk[0] = 8'(c);
      pk[1] = 8'(r);
      pk[2] = 8'(ch);
      if (fpos < 3) begin
        for (int i = 0; i <= fpos; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(pk[i], i == fpos);
        end
        exp_drop++;
      end else begin
        for (int i = 0; i < 3; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(pk[i], 1'b0);
        end
        if (ovr) send(8'hAA, 1'b0);
        badp = !(c < 80 && r < 30);
        if (!badp) exp_q.push_back({12'(r * 80 + c), 8'(ch), 8'h0F});
        if (badp || ovr) exp_drop++;
      end
      w = 0;
      while (busy_a && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) chk("rand_idle_wait", 32'(busy_a), 0);
    end
    rand_rdy = 1'b0;
    rdy = 1'b1;
    tick(); tick();
    chk("rand_nwrites", 32'(got_a.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++)
      chk($sformatf("rand_write%0d", i), 32'(got_a[i]), 32'(exp_q[i]));
    chk("rand_drop", 32'(drop_a), 32'(exp_drop));
    chk("rand_err_pulses", 32'(nerr_a - n0), 32'(exp_drop));

    // Saturation of the drop counter.
    n0 = nerr_a;
    repeat (260) send(8'h00, 1'b1);
    tick();
    chk("sat_drop", 32'(drop_a), 255);
    chk("sat_err_pulses", 32'(nerr_a - n0), 260);

    // 5: attribute packet with 5 stalled cycles and an overrun byte mid-stall.
    rst_a = 1'b1;
    rst_b = 1'b0;
    rdy = 1'b0;
    tick();
    n0 = nerr_b;
    send(8'h0A, 1'b0);
    send(8'h01, 1'b0);
    send(8'h43, 1'b0);
    send(8'h1E, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      rdy = (i == 5);
      rx_valid = (i == 1);
      rx_data = 8'h55;
      chk($sformatf("t5_wr_en_c%0d", i), 32'(wr_en_b), 1);
      chk($sformatf("t5_stable_c%0d", i), {4'h0, wr_addr_b, wr_char_b, wr_attr_b},
          {4'h0, 12'd90, 8'h43, 8'h1E});
      if (i == 2) chk("t5_ovr_err", 32'(err_b), 1);
      tick();
      rx_valid = 1'b0;
    end
    chk("t5_wr_en_done", 32'(wr_en_b), 0);
    chk("t5_busy_done", 32'(busy_b), 0);
    tick();
    chk("t5_nwrites", 32'(got_b.size()), 1);
    chk("t5_drop", 32'(drop_b), 1);
    chk("t5_err_pulses", 32'(nerr_b - n0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_text_cmd_decoder.md
Name: uart_text_cmd_decoder

Overview:
- Parametrised successor to the fixed UART write path of the VGA text controller, which handles column, row and character bytes with a fixed grid.
- Sits between the UART receiver and the character/attribute buffer.
- Assembles byte packets (column, row, character, optional colour attribute) and range-checks coordinates.
- Computes a linear buffer address and issues one back-pressured write per valid packet.
- Malformed, out-of-range or stalled packets are dropped and counted.

Parameters:
- COLS, 80, text columns.
- ROWS, 30, text rows.
- ADDR_W, 12, buffer address width; must satisfy 2**ADDR_W >= COLS*ROWS.
- ATTR_EN, 0, 1 = packet carries a 4th attribute byte; 0 = 3-byte packets.
- DEFAULT_ATTR, 8'h0F, attribute emitted when ATTR_EN=0.
- TIMEOUT_CYC, 20000, idle cycles allowed mid-packet before abort (>= ~8 byte times at 115200 baud, 25 MHz).

Ports:
- clk_i  in  1  system clock, 25 MHz.
- rst_i  in  1  asynchronous, active-high reset.
- rx_valid_i  in  1  one-cycle strobe: byte received.
- rx_data_i  in  8  received byte, valid with rx_valid_i.
- rx_ferr_i  in  1  framing error, qualified by rx_valid_i.
- wr_ready_i  in  1  buffer accepts the write this cycle.
- wr_en_o  out  1  write request, held until accepted.
- wr_addr_o  out  ADDR_W  row*COLS+col.
- wr_char_o  out  8  character code.
- wr_attr_o  out  8  attribute byte.
- busy_o  out  1  packet in progress (state != S_COL).
- err_o  out  1  one-cycle pulse per dropped packet or overrun byte.
- drop_cnt_o  out  8  saturating count of err_o pulses.

Behaviour:
- One clock. Reset is asynchronous, active-high. All registers update on the rising edge of clk_i.
- Reset values: all outputs 0. Internal state S_COL, timer 0, byte registers 0.
- States:
  - S_COL: a byte is accepted as col → S_ROW.
  - S_ROW: byte → row → S_CHAR.
  - S_CHAR: byte → char → S_ATTR if ATTR_EN, else S_CHK.
  - S_ATTR: byte → attr → S_CHK.
  - S_CHK: one cycle.
    - If col < COLS and row < ROWS: register wr_addr_o = row*COLS+col (truncated to ADDR_W), wr_char_o, wr_attr_o (DEFAULT_ATTR when ATTR_EN=0), set wr_en_o → S_WRITE.
    - Otherwise: err_o pulse, drop count +1 → S_COL.
  - S_WRITE: hold wr_en_o/addr/char/attr stable until wr_en_o && wr_ready_i. The following cycle wr_en_o=0 → S_COL.
- Latency: last packet byte accepted at cycle N → S_CHK at N+1 → wr_en_o high at N+2. With wr_ready_i=1 it is a single-cycle pulse.
- Framing error: rx_valid_i && rx_ferr_i in any byte-collect state discards the byte and any partial packet → S_COL, err_o pulse, count +1.
- Overrun: rx_valid_i in S_CHK or S_WRITE discards the byte and raises an err_o pulse with count +1. The pending write still completes.
- Timeout:
  - The timer clears on every accepted byte and in S_COL. It increments in S_ROW/S_CHAR/S_ATTR.
  - Reaching TIMEOUT_CYC-1 → S_COL, err_o pulse, count +1.
  - The timer is frozen in S_CHK/S_WRITE; back-pressure never times out.
- Simultaneous rx_valid_i and timeout expiry: the byte wins; it is accepted and the timer clears.
- drop_cnt_o saturates at 255. err_o never asserts twice in one cycle; coincident events produce a single increment.
- Reset mid-packet or mid-write: immediate abort. No write is completed, and wr_en_o drops asynchronously.
- busy_o = (state != S_COL), registered.

Test Plan:
1. Baseline write: ATTR_EN=0, wr_ready_i=1; send bytes 0x00, 0x00, 0x41 → exactly one wr_en_o pulse two cycles after the 3rd strobe, with addr 0, char 0x41, attr 0x0F; err_o never asserts.
2. Last cell: send col 79, row 29, char 0x5A → one write with addr 2399, char 0x5A.
3. Out-of-range column: send col 80, row 0, char 0x41 → no wr_en_o, one err_o pulse, drop_cnt_o=1, busy_o low afterwards. A following valid triple writes normally.
4. Timeout: send bytes 0x05, 0x03, then stay idle for TIMEOUT_CYC cycles → err_o pulse, drop_cnt_o +1. Then send 0x01, 0x02, 0x42 → write with addr 161, char 0x42; the earlier bytes have no effect.
5. Attribute and back-pressure: ATTR_EN=1; send 0x0A, 0x01, 0x43, 0x1E with wr_ready_i low for 5 cycles → wr_en_o held 6 cycles with addr 90, char 0x43, attr 0x1E stable throughout. A byte strobed during the stall produces an err_o pulse and the write still completes.
6. Framing error and reset: assert rx_ferr_i on the row byte → abort with err_o pulse. Separately, assert rst_i after the row byte → all outputs 0 immediately; a subsequent 0x00, 0x00, 0x41 writes addr 0 correctly.
